bridge_n: RTL and testbench

Parametrised system bridge between the CPU data port and memory-mapped peripherals. It decodes CPU bus accesses onto NUM_TIMERS built-in timer channels and a small interrupt controller, registers the read data, and latches interrupt events into a pending register. It drives the masked 6-bit HWInt vector into CP0. It sits between the CPU/DM address decode and the peripherals, and replaces the fixed two-timer, combinational-interrupt bridge.

---
 rtl/bridge_pkg.sv | 32 +++
 rtl/bridge_n_timer_ch.sv | 101 ++++++++++
 rtl/bridge_n.sv | 131 +++++++++++++
 tb/tb_bridge_n.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge:
// register offsets, CTRL fields, timer modes and the byte-mask helper.
package bridge_pkg;

  localparam int HWINT_W = 6;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_RSV2    = 2'd2,
    MODE_RSV3    = 2'd3
  } mode_e;

  function automatic logic [31:0] byte_mask(
    input logic [3:0] m
  );
    return {{8{m[3]}}, {8{m[2]}},
            {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/bridge_n_timer_ch.sv
// One timer channel: CTRL/PRESET/COUNT registers,
// down-counting and the registered expiry event.
module timer_ch
  import bridge_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bmask_i,
  output logic [31:0] rdata_o,
  output logic        event_o
);

  logic        en_q, en_d;
  logic        im_q, im_d;
  mode_e       mode_q, mode_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        ev_q, ev_d;

  logic        ctrl_wr;
  logic        pre_wr;
  logic        expire;
  logic [3:0]  ctrl_m;
  logic [31:0] pre_m;

  always_comb begin
    ctrl_wr = we_i && (off_i == OFF_CTRL);
    pre_wr  = we_i && (off_i == OFF_PRESET);
    ctrl_m  = ({im_q, mode_q, en_q} & ~bmask_i[3:0])
            | (wdata_i[3:0] & bmask_i[3:0]);
    pre_m   = (preset_q & ~bmask_i)
            | (wdata_i & bmask_i);
    // a PRESET load pre-empts the 1->0 step
    expire  = en_q && (count_q == 32'd1) && !pre_wr;

    en_d     = en_q;
    im_d     = im_q;
    mode_d   = mode_q;
    preset_d = preset_q;
    count_d  = count_q;
    ev_d     = expire && im_q;

    if (ctrl_wr) begin
      en_d   = ctrl_m[CTRL_EN];
      mode_d = mode_e'(ctrl_m[CTRL_MODE +: 2]);
      im_d   = ctrl_m[CTRL_IM];
    end else if (expire && mode_q != MODE_RELOAD) begin
      en_d = 1'b0;
    end

    if (pre_wr) begin
      preset_d = pre_m;
      count_d  = pre_m;
    end else if (en_q && count_q != 32'd0) begin
      count_d = count_q - 32'd1;
    end else if (en_q && mode_q == MODE_RELOAD) begin
      count_d = preset_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      im_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      preset_q <= '0;
      count_q  <= '0;
      ev_q     <= 1'b0;
    end else begin
      en_q     <= en_d;
      im_q     <= im_d;
      mode_q   <= mode_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      ev_q     <= ev_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (sel_i) begin
      unique case (1'b1)
        off_i == OFF_CTRL:
          rdata_o = {28'd0, im_q, mode_q, en_q};
        off_i == OFF_PRESET:
          rdata_o = preset_q;
        off_i == OFF_COUNT:
          rdata_o = count_q;
        default:
          rdata_o = '0;
      endcase
    end
  end

  assign event_o = ev_q;

endmodule

// File: rtl/bridge_n.sv
// Bridge top: address decode, timer channels, interrupt
// controller (PEND/MASK) and the registered read port.
module bridge_n
  import bridge_pkg::*;
#(
  parameter int          NUM_TIMERS = 2,
  parameter int          NUM_EXT    = 1,
  parameter logic [31:0] TIMER_BASE = 32'h0000_7f00,
  parameter logic [31:0] IC_BASE    = 32'h0000_7f80
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [31:0]        PrAddr,
  input  logic [31:0]        PrWData,
  input  logic [3:0]         PrMask,
  input  logic               PrWrite,
  input  logic               PrRead,
  input  logic [NUM_EXT-1:0] ExtInt,
  output logic [31:0]        PrRData,
  output logic               PrRValid,
  output logic [HWINT_W-1:0] HWInt
);

  logic [31:0] bm;
  logic [1:0]  off;
  logic        unused_addr;

  assign bm          = byte_mask(PrMask);
  assign off         = PrAddr[3:2];
  assign unused_addr = ^PrAddr[1:0];

  logic [NUM_TIMERS-1:0] t_ev;
  logic [31:0]           t_rd [NUM_TIMERS];

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
    localparam logic [27:0] BLK =
      TIMER_BASE[31:4] + 28'(i);
    logic hit;
    assign hit = (PrAddr[31:4] == BLK);
    timer_ch u_ch (
      .clk_i   (Clk),
      .rst_ni  (Rst),
      .sel_i   (hit),
      .we_i    (hit && PrWrite),
      .off_i   (off),
      .wdata_i (PrWData),
      .bmask_i (bm),
      .rdata_o (t_rd[i]),
      .event_o (t_ev[i])
    );
  end

  logic [NUM_EXT-1:0] sync_q;
  logic [NUM_EXT-1:0] prev_q;
  logic [NUM_EXT-1:0] ext_ev;

  assign ext_ev = sync_q & ~prev_q;

  logic [HWINT_W-1:0] src;

  always_comb begin
    src = '0;
    for (int i = 0; i < NUM_TIMERS; i++)
      src[i] = t_ev[i];
    for (int j = 0; j < NUM_EXT; j++)
      src[NUM_TIMERS + j] = ext_ev[j];
  end

  logic               ic_hit;
  logic [HWINT_W-1:0] pend_q, pend_d;
  logic [HWINT_W-1:0] mask_q, mask_d;
  logic [HWINT_W-1:0] clr;

  assign ic_hit = (PrAddr[31:4] == IC_BASE[31:4]);

  always_comb begin
    clr    = '0;
    mask_d = mask_q;
    if (PrWrite && ic_hit && off == OFF_PEND)
      clr = PrWData[HWINT_W-1:0] & bm[HWINT_W-1:0];
    if (PrWrite && ic_hit && off == OFF_MASK)
      mask_d = (mask_q & ~bm[HWINT_W-1:0])
             | (PrWData[HWINT_W-1:0] & bm[HWINT_W-1:0]);
    // a new event beats a same-cycle clear
    pend_d = (pend_q & ~clr) | src;
  end

  logic [31:0] rd_mux;
  logic [31:0] rdata_q;
  logic        rvalid_q;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_TIMERS; i++)
      rd_mux = rd_mux | t_rd[i];
    if (ic_hit) begin
      unique case (1'b1)
        off == OFF_PEND:
          rd_mux = {{(32-HWINT_W){1'b0}}, pend_q};
        off == OFF_MASK:
          rd_mux = {{(32-HWINT_W){1'b0}}, mask_q};
        default:
          rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync_q   <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      sync_q   <= ExtInt;
      prev_q   <= sync_q;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      rvalid_q <= PrRead;
      if (PrRead)
        rdata_q <= rd_mux;
    end
  end

  assign PrRData  = rdata_q;
  assign PrRValid = rvalid_q;
  assign HWInt    = pend_q & mask_q;

endmodule

// File: tb/tb_bridge_n.sv
// Directed bench for bridge_n: timers, interrupt controller,
// byte masks, unmapped space and reset behaviour.
module tb_bridge_n;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] PrAddr;
  logic [31:0] PrWData;
  logic [3:0]  PrMask;
  logic        PrWrite;
  logic        PrRead;
  logic [0:0]  ExtInt;
  logic [31:0] PrRData;
  logic        PrRValid;
  logic [5:0]  HWInt;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] T0 = 32'h7f00;
  localparam logic [31:0] T1 = 32'h7f10;
  localparam logic [31:0] IC = 32'h7f80;

  always #5 Clk = ~Clk;

  bridge_n dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .PrAddr   (PrAddr),
    .PrWData  (PrWData),
    .PrMask   (PrMask),
    .PrWrite  (PrWrite),
    .PrRead   (PrRead),
    .ExtInt   (ExtInt),
    .PrRData  (PrRData),
    .PrRValid (PrRValid),
    .HWInt    (HWInt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic idle();
    @(negedge Clk);
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0]  m = 4'hF);
    @(negedge Clk);
    PrAddr = a; PrWData = d; PrMask = m; PrWrite = 1'b1;
    @(posedge Clk);
    #1;
    PrWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] exp,
                    input string tag);
    @(negedge Clk);
    PrAddr = a; PrRead = 1'b1;
    @(posedge Clk);
    #1;
    PrRead = 1'b0;
    chk(tag, PrRData, exp);
  endtask

  initial begin
    Rst = 1'b0; PrAddr = '0; PrWData = '0; PrMask = '0;
    PrWrite = 1'b0; PrRead = 1'b0; ExtInt = 1'b0;

    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      PrAddr  = 32'h7f00 | ($urandom_range(0, 15) << 2);
      PrWData = $urandom();
      PrMask  = 4'hF;
      PrWrite = 1'b1;
      PrRead  = 1'b1;
      @(posedge Clk);
      #1;
      chk("rst_hwint", {26'd0, HWInt}, 32'd0);
      chk("rst_rvalid", {31'd0, PrRValid}, 32'd0);
      chk("rst_rdata", PrRData, 32'd0);
    end
    @(negedge Clk);
    PrWrite = 1'b0; PrRead = 1'b0; Rst = 1'b1;

    for (int k = 0; k < 4; k++) begin
      rd(T0 + 32'(4 * k), 32'd0, "rst_t0");
      rd(T1 + 32'(4 * k), 32'd0, "rst_t1");
      rd(IC + 32'(4 * k), 32'd0, "rst_ic");
    end
    chk("rd_valid", {31'd0, PrRValid}, 32'd1);
    idle();
    chk("valid_1cyc", {31'd0, PrRValid}, 32'd0);

    // one-shot on timer 0
    wr(IC + 4, 32'h01);
    wr(T0 + 4, 32'd5);
    wr(T0 + 0, 32'h9);
    for (int k = 5; k >= 0; k--) begin
      rd(T0 + 8, 32'(k), "os_count");
      chk("os_hwint", {26'd0, HWInt},
          (k == 0) ? 32'd1 : 32'd0);
    end
    rd(T0 + 0, 32'h8, "os_ctrl");
    rd(IC + 0, 32'h1, "os_pend");
    rd(T0 + 8, 32'd0, "os_stays0");
    wr(IC + 0, 32'h01);
    chk("os_w1c", {26'd0, HWInt}, 32'd0);

    // auto-reload on timer 1
    wr(IC + 4, 32'h03);
    wr(T1 + 4, 32'd3);
    wr(T1 + 0, 32'hB);
    idle(); chk("ar_c1", {26'd0, HWInt}, 32'd0);
    idle(); chk("ar_c2", {26'd0, HWInt}, 32'd0);
    idle(); chk("ar_c3", {26'd0, HWInt}, 32'd0);
    idle(); chk("ar_c4", {26'd0, HWInt}, 32'h2);
    wr(IC + 0, 32'h02);
    chk("ar_w1c", {26'd0, HWInt}, 32'd0);
    idle(); chk("ar_c6", {26'd0, HWInt}, 32'd0);
    idle(); chk("ar_c7", {26'd0, HWInt}, 32'd0);
    wr(IC + 0, 32'h02);
    chk("ar_setwins", {26'd0, HWInt}, 32'h2);
    wr(T1 + 0, 32'h0);
    chk("ar_held", {26'd0, HWInt}, 32'h2);
    wr(IC + 0, 32'h3F);
    chk("ar_clr", {26'd0, HWInt}, 32'd0);

    // external interrupt edge
    wr(IC + 4, 32'h3F);
    @(negedge Clk);
    ExtInt = 1'b1;
    @(posedge Clk);
    #1;
    chk("ext_sync", {26'd0, HWInt}, 32'd0);
    idle();
    chk("ext_pend", {26'd0, HWInt}, 32'h4);
    wr(IC + 0, 32'h04);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("ext_level", {26'd0, HWInt}, 32'd0);
    end
    ExtInt = 1'b0;

    // byte masks, COUNT read-only, read/write collision
    wr(T0 + 4, 32'h12345678);
    wr(T0 + 4, 32'hAABBCCDD, 4'b0010);
    rd(T0 + 4, 32'h1234CC78, "bm_preset");
    rd(T0 + 8, 32'h1234CC78, "bm_count");
    wr(T0 + 8, 32'h0);
    rd(T0 + 8, 32'h1234CC78, "count_ro");
    @(negedge Clk);
    PrAddr = T0 + 4; PrWData = 32'h55; PrMask = 4'hF;
    PrRead = 1'b1; PrWrite = 1'b1;
    @(posedge Clk);
    #1;
    PrRead = 1'b0; PrWrite = 1'b0;
    chk("rw_old", PrRData, 32'h1234CC78);
    rd(T0 + 4, 32'h55, "rw_new");
    idle();
    chk("hold_data", PrRData, 32'h55);
    chk("hold_valid", {31'd0, PrRValid}, 32'd0);

    // unmapped space
    rd(32'h7f0C, 32'd0, "um_t0c");
    chk("um_valid", {31'd0, PrRValid}, 32'd1);
    rd(32'h7f40, 32'd0, "um_hole");
    rd(IC + 8, 32'd0, "um_ic8");
    idle();
    chk("um_vdrop", {31'd0, PrRValid}, 32'd0);

    // reset mid-count
    wr(IC + 4, 32'h01);
    wr(T0 + 4, 32'd2);
    wr(T0 + 0, 32'h9);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    for (int k = 0; k < 3; k++) idle();
    rd(IC + 0, 32'd0, "mr_pend");
    rd(T0 + 8, 32'd0, "mr_count");
    rd(T0 + 0, 32'd0, "mr_ctrl");
    chk("mr_hwint", {26'd0, HWInt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
